// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed register file with byte strobes.
// Independent AW/W holding registers, latency-configurable reads, completion counters.
module axi4_lite_slave_mem #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         MEM_DEPTH     = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = 32'h0000_1000,
    parameter int                         READ_LATENCY  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDRESS_WIDTH-1:0]   araddr,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic [15:0]                wr_done_count,
    output logic [15:0]                rd_done_count
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] WINDOW   = ADDRESS_WIDTH'(MEM_DEPTH * NB);
    localparam logic [2:0]               LAT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    function automatic logic [1:0] decode_resp(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        if ((addr < BASE_ADDR) || (off >= WINDOW))
            return 2'b11;
        if (addr[LSB-1:0] != '0)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [IDXW-1:0] word_index(input logic [ADDRESS_WIDTH-1:0] addr);
        return IDXW'((addr - BASE_ADDR) >> LSB);
    endfunction

    logic                       aw_full_q, w_full_q;
    logic [ADDRESS_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]      w_data_q;
    logic [NB-1:0]              w_strb_q;
    logic                       bvalid_q;
    logic [1:0]                 bresp_q;
    logic [15:0]                wr_cnt_q, rd_cnt_q;
    logic [DATA_WIDTH-1:0]      mem_q [MEM_DEPTH];

    r_state_e                   r_state_q, r_state_d;
    logic [ADDRESS_WIDTH-1:0]   ar_addr_q, ar_addr_d;
    logic [2:0]                 lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       rd_sample;
    logic [ADDRESS_WIDTH-1:0]   rd_addr;

    logic                       aw_hs, w_hs, b_hs, r_hs, commit;
    logic [1:0]                 wr_resp;
    logic [IDXW-1:0]            wr_idx;
    logic [DATA_WIDTH-1:0]      wr_merged;

    // Readies are gated by rst_n so they read low for the whole reset assertion.
    assign awready = rst_n && !aw_full_q;
    assign wready  = rst_n && !w_full_q;
    assign arready = rst_n && (r_state_q == R_IDLE);

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid_q && bready;
    assign r_hs   = rvalid && rready;
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    assign wr_resp = decode_resp(aw_addr_q);
    assign wr_idx  = word_index(aw_addr_q);

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign wr_merged[gi*8 +: 8] = w_strb_q[gi] ? w_data_q[gi*8 +: 8]
                                                   : mem_q[wr_idx][gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_cnt_q  <= 16'd0;
            rd_cnt_q  <= 16'd0;
        end else begin
            if (commit) begin
                aw_full_q <= 1'b0;
            end else if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (commit) begin
                w_full_q <= 1'b0;
            end else if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
            if (b_hs)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (r_hs)
                rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (commit && (wr_resp == 2'b00)) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            lat_cnt_q <= 3'd0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            lat_cnt_q <= lat_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Sampling happens on the edge that makes rvalid rise READ_LATENCY cycles
    // after the AR handshake; with latency 1 that is the handshake edge itself.
    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        lat_cnt_d = lat_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_sample = 1'b0;
        rd_addr   = ar_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    ar_addr_d = araddr;
                    if (READ_LATENCY == 1) begin
                        rd_sample = 1'b1;
                        rd_addr   = araddr;
                        r_state_d = R_RESP;
                    end else begin
                        lat_cnt_d = LAT_LOAD;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt_q <= 3'd1) begin
                    rd_sample = 1'b1;
                    r_state_d = R_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            R_RESP: begin
                if (rready)
                    r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_sample) begin
            rresp_d = decode_resp(rd_addr);
            rdata_d = (rresp_d == 2'b00) ? mem_q[word_index(rd_addr)] : '0;
        end
    end

    assign bvalid        = bvalid_q;
    assign bresp         = bresp_q;
    assign rvalid        = (r_state_q == R_RESP);
    assign rdata         = rdata_q;
    assign rresp         = rresp_q;
    assign wr_done_count = wr_cnt_q;
    assign rd_done_count = rd_cnt_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem (32-bit data, 8 words at 0x1000, read latency 2).
module tb_axi4_lite_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] wr_done_count, rd_done_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_wr = 16'd0;
    logic [15:0] exp_rd = 16'd0;
    logic [31:0] exp_mem [8];
    logic [1:0]  resp;
    logic [31:0] data;

    axi4_lite_slave_mem #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_DEPTH(8),
        .BASE_ADDR(32'h0000_1000), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .wr_done_count(wr_done_count), .rd_done_count(rd_done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_wr_cnt"}, 64'(wr_done_count), 64'(exp_wr));
        chk({tag, "_rd_cnt"}, 64'(rd_done_count), 64'(exp_rd));
    endtask

    // Both channels presented together; bready held high. Entered and left on a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] strb, output logic [1:0] r);
        int   n;
        logic aw_go, w_go;
        awaddr = addr; wdata = d; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awready; w_go = wready;
            @(negedge clk); n++;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        r = bresp;
        if (!bvalid) chk("write_timeout", 64'(bvalid), 64'd1);
        else exp_wr++;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int   n;
        logic ar_go;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            ar_go = arready;
            @(negedge clk); n++;
            if (ar_go) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        d = rdata; r = rresp;
        if (!rvalid) chk("read_timeout", 64'(rvalid), 64'd1);
        else exp_rd++;
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_awready", 64'(awready), 64'd1);
        chk("rel_wready", 64'(wready), 64'd1);
        chk("rel_arready", 64'(arready), 64'd1);
        @(negedge clk);

        // Test 1: same-cycle AW/W, latency checks on B and R
        awaddr = 32'h1004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_bvalid_n1", 64'(bvalid), 64'd0);
        chk("t1_awready_full", 64'(awready), 64'd0);
        @(negedge clk);
        chk("t1_bvalid_n2", 64'(bvalid), 64'd1);
        chk("t1_bresp", 64'(bresp), 64'd0);
        @(negedge clk);
        exp_wr++;
        chk("t1_bvalid_drop", 64'(bvalid), 64'd0);
        chk("t1_awready_back", 64'(awready), 64'd1);
        araddr = 32'h1004; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("t1_rvalid_m1", 64'(rvalid), 64'd0);
        chk("t1_arready_busy", 64'(arready), 64'd0);
        @(negedge clk);
        chk("t1_rvalid_m2", 64'(rvalid), 64'd1);
        chk("t1_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("t1_rresp", 64'(rresp), 64'd0);
        @(negedge clk);
        exp_rd++;
        chk("t1_rvalid_drop", 64'(rvalid), 64'd0);
        chk("t1_arready_back", 64'(arready), 64'd1);
        chk_counts("t1");
        exp_mem[1] = 32'hDEADBEEF;

        // Test 2: partial strobes
        do_write(32'h1004, 32'h11223344, 4'h5, resp);
        chk("t2_bresp", 64'(resp), 64'd0);
        do_read(32'h1004, data, resp);
        chk("t2_rdata", 64'(data), 64'hDE22BE44);
        chk("t2_rresp", 64'(resp), 64'd0);
        exp_mem[1] = 32'hDE22BE44;

        // Test 3: W ahead of AW, stalled B, second pair queued behind it
        bready = 1'b0; wdata = 32'h0000_00A5; wstrb = 4'h1; wvalid = 1'b1;
        chk("t3_wready_empty", 64'(wready), 64'd1);
        @(negedge clk);
        wvalid = 1'b0;
        chk("t3_wready_held1", 64'(wready), 64'd0);
        @(negedge clk);
        chk("t3_wready_held2", 64'(wready), 64'd0);
        @(negedge clk);
        chk("t3_wready_held3", 64'(wready), 64'd0);
        chk("t3_bvalid_noaw", 64'(bvalid), 64'd0);
        awaddr = 32'h1008; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("t3_bvalid_early", 64'(bvalid), 64'd0);
        chk("t3_wready_precommit", 64'(wready), 64'd0);
        @(negedge clk);
        chk("t3_bvalid_first", 64'(bvalid), 64'd1);
        chk("t3_bresp_first", 64'(bresp), 64'd0);
        chk("t3_wready_after_commit", 64'(wready), 64'd1);
        chk("t3_awready_after_commit", 64'(awready), 64'd1);
        awaddr = 32'h100C; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t3_bvalid_stall2", 64'(bvalid), 64'd1);
        chk("t3_bresp_stall2", 64'(bresp), 64'd0);
        @(negedge clk);
        chk("t3_bvalid_stall3", 64'(bvalid), 64'd1);
        chk("t3_awready_pending", 64'(awready), 64'd0);
        chk("t3_wready_pending", 64'(wready), 64'd0);
        @(negedge clk);
        chk("t3_bvalid_stall4", 64'(bvalid), 64'd1);
        chk("t3_wr_cnt_stalled", 64'(wr_done_count), 64'(exp_wr));
        bready = 1'b1;
        @(negedge clk);
        exp_wr++;
        chk("t3_bvalid_gap", 64'(bvalid), 64'd0);
        chk("t3_wr_cnt_one", 64'(wr_done_count), 64'(exp_wr));
        @(negedge clk);
        chk("t3_bvalid_second", 64'(bvalid), 64'd1);
        chk("t3_bresp_second", 64'(bresp), 64'd0);
        @(negedge clk);
        exp_wr++;
        chk("t3_bvalid_done", 64'(bvalid), 64'd0);
        chk_counts("t3");
        exp_mem[2] = 32'h0000_00A5;
        exp_mem[3] = 32'h12345678;
        do_read(32'h1008, data, resp);
        chk("t3_rdata_1008", 64'(data), 64'h000000A5);

        // Test 4: decode errors
        do_read(32'h1020, data, resp);
        chk("t4_rresp_1020", 64'(resp), 64'd3);
        chk("t4_rdata_1020", 64'(data), 64'd0);
        do_read(32'h0FFC, data, resp);
        chk("t4_rresp_0ffc", 64'(resp), 64'd3);
        chk("t4_rdata_0ffc", 64'(data), 64'd0);
        do_write(32'h1002, 32'hFFFFFFFF, 4'hF, resp);
        chk("t4_bresp_1002", 64'(resp), 64'd2);
        do_write(32'h1020, 32'hFFFFFFFF, 4'hF, resp);
        chk("t4_bresp_1020", 64'(resp), 64'd3);
        for (int i = 0; i < 8; i++) begin
            do_read(32'h1000 + 32'(i * 4), data, resp);
            chk($sformatf("t4_mem%0d", i), 64'(data), 64'(exp_mem[i]));
        end
        chk_counts("t4");

        // Test 5: reset with responses pending
        araddr = 32'h1004; arvalid = 1'b1; rready = 1'b0;
        awaddr = 32'h1010; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_rvalid_pending", 64'(rvalid), 64'd1);
        chk("t5_bvalid_pending", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        exp_wr = 16'd0; exp_rd = 16'd0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
        chk("t5_rvalid_rst", 64'(rvalid), 64'd0);
        chk("t5_bvalid_rst", 64'(bvalid), 64'd0);
        chk("t5_arready_rst", 64'(arready), 64'd0);
        chk_counts("t5_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_rvalid_after", 64'(rvalid), 64'd0);
        chk("t5_bvalid_after", 64'(bvalid), 64'd0);
        chk_counts("t5_after");
        do_read(32'h1004, data, resp);
        chk("t5_rdata_cleared", 64'(data), 64'd0);
        chk("t5_rresp", 64'(resp), 64'd0);

        // Test 6: write commit and read sample on the same edge
        do_write(32'h100C, 32'h55AA55AA, 4'hF, resp);
        chk("t6_bresp_pre", 64'(resp), 64'd0);
        awaddr = 32'h100C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h100C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t6_bvalid_n1", 64'(bvalid), 64'd0);
        chk("t6_rvalid_n1", 64'(rvalid), 64'd0);
        @(negedge clk);
        chk("t6_bvalid_n2", 64'(bvalid), 64'd1);
        chk("t6_rvalid_n2", 64'(rvalid), 64'd1);
        chk("t6_rdata_old", 64'(rdata), 64'h55AA55AA);
        @(negedge clk);
        exp_wr++; exp_rd++;
        chk_counts("t6");
        do_read(32'h100C, data, resp);
        chk("t6_rdata_new", 64'(data), 64'hCAFEF00D);
        chk_counts("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_mem.md
Name: axi4_lite_slave_mem

Overview:
- Parametrised AXI4-Lite memory slave: word-addressed register file of configurable depth and width, with byte strobes.
- Address decode returns an error response for unaligned or out-of-window accesses.
- AW and W are accepted independently; read latency is configurable; completed transactions are counted.
- Sits behind the AXI4-Lite VIP master as the DUT in master-VIP/slave-RTL examples, and as a generic peripheral register bank.

Parameters:
- DATA_WIDTH, 32, data bus width; 32 or 64 only.
- ADDRESS_WIDTH, 32, address bus width.
- MEM_DEPTH, 8, number of DATA_WIDTH words; power of 2, at least 2.
- BASE_ADDR, 32'h0000_1000, byte address of word 0; aligned to MEM_DEPTH*(DATA_WIDTH/8).
- READ_LATENCY, 1, cycles from AR handshake to first rvalid cycle; 1..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- awvalid  in  1 / awready  out  1 / awaddr  in  ADDRESS_WIDTH  write address channel.
- wvalid  in  1 / wready  out  1 / wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8  write data channel.
- bvalid  out  1 / bready  in  1 / bresp  out  2  write response channel.
- arvalid  in  1 / arready  out  1 / araddr  in  ADDRESS_WIDTH  read address channel.
- rvalid  out  1 / rready  in  1 / rdata  out  DATA_WIDTH / rresp  out  2  read data channel.
- wr_done_count  out  16  count of B handshakes; wraps at 16'hFFFF -> 0.
- rd_done_count  out  16  count of R handshakes; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset, asynchronous and immediate: all outputs 0; awready=wready=arready=0 while rst_n is low; memory words 0; holding registers empty; counters 0. The first cycle after release has awready=wready=arready=1.
- Any transaction in flight at reset is dropped. No response is issued for it after release.
- Decode, identical for writes and reads:
  - off = addr - BASE_ADDR; resp=2'b11 (DECERR) if addr < BASE_ADDR or off >= MEM_DEPTH*(DATA_WIDTH/8).
  - Else resp=2'b10 (SLVERR) if the low log2(DATA_WIDTH/8) address bits are non-zero.
  - Else resp=2'b00 (OKAY), with word index = off >> log2(DATA_WIDTH/8).
- Write path:
  - One AW holding register and one W holding register.
  - awready = AW holding register empty; wready = W holding register empty. Both are registered and depend on no valid input.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens in the first cycle where both holds are full and bvalid=0. At that edge:
    - if OKAY, write the bytes where wstrb[i]=1; bytes with wstrb[i]=0 are unchanged;
    - if error, memory is untouched;
    - bvalid<=1 and bresp<=decoded resp;
    - both holds are emptied, so awready and wready rise in the next cycle.
  - Minimum latency: AW and W handshakes in cycle N -> bvalid high in cycle N+2.
  - bvalid and bresp hold stable until bready; bvalid drops the cycle after the handshake.
  - A new AW/W pair may be accepted while bvalid waits. Its commit waits for bvalid=0. At most one response plus one pending pair exist.
- Read path, FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE:
  - arready=1 only in R_IDLE.
  - AR handshake: capture address, load the latency counter with READ_LATENCY-1, go to R_WAIT.
  - R_WAIT: decrement the counter. At the edge where it is 0, sample memory and go to R_RESP with rvalid=1. Data = mem[index] if OKAY, else all zeros. rresp = decoded resp.
  - AR handshake in cycle N -> rvalid first high in cycle N+READ_LATENCY.
  - R_RESP: rvalid, rdata and rresp stay stable until rready. Handshake -> R_IDLE; rvalid=0 and arready=1 in the next cycle.
- Read/write collision: if a write commits at the same edge a read samples the same word, the read returns the pre-write value.
- Counters: wr_done_count increments on bvalid&&bready; rd_done_count increments on rvalid&&rready.
- Error responses count the same as OKAY responses.

Test Plan:
Config for all scenarios: DATA_WIDTH=32, MEM_DEPTH=8, BASE_ADDR=0x1000, READ_LATENCY=2; window 0x1000-0x101F.
1. AW 0x1004 and W 0xDEADBEEF/strb 0xF in the same cycle N, bready=1 -> bvalid in N+2 with bresp 00. AR 0x1004 in cycle M, rready=1 -> rvalid in M+2 with rdata 0xDEADBEEF, rresp 00. Both counters read 1.
2. After test 1, write 0x1004 data 0x11223344 strb 0x5 -> bresp 00; readback 0xDE22BE44.
3. W (0x0000_00A5, strb 0x1, to 0x1008) driven 3 cycles before AW; bready low for 4 cycles:
   - wready stays low until the commit; bvalid is held with bresp stable;
   - a second AW/W pair is accepted during the stall and its bvalid appears only after the first B handshake;
   - wr_done_count advances by 2.
4. Reads of 0x1020 and 0x0FFC -> rresp 11, rdata 0. Write 0x1002 -> bresp 10 and all memory words unchanged. Counters still increment.
5. Drop rst_n while rvalid waits on rready=0 -> rvalid, bvalid and counters are 0 immediately. After release, reading 0x1004 returns 0x0000_0000.
6. Write to 0x100C commits at the same edge a read of 0x100C samples -> the read returns the old value and a subsequent read returns the new value.
